// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: samples the PC, reads instruction memory over a
// req/ack handshake, buffers the word and hands it to decode with valid/ready.
// Redirect flushes never withdraw an outstanding memory request; that request
// is drained and its data thrown away. Misaligned PCs park the unit in a
// sticky fault until a flush or reset.
module instr_fetch_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [31:0]          PC,
  input  logic                 Flush,
  output logic                 PCStall,
  output logic                 IMemReq,
  output logic [31:0]          IMemAddr,
  input  logic                 IMemAck,
  input  logic [31:0]          IMemData,
  output logic [31:0]          Instr,
  output logic [31:0]          InstrPC,
  output logic                 InstrValid,
  input  logic                 DecodeReady,
  output logic                 Fault,
  output logic [CNT_WIDTH-1:0] FetchCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic                 imem_req_q, imem_req_d;
  logic [31:0]          imem_addr_q, imem_addr_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          instr_pc_q, instr_pc_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 fault_q, fault_d;
  logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic pc_aligned;
  logic latch_pc;

  // The PC is consumed only when the unit is free to start a new fetch;
  // there is deliberately no path from IMemAck into this decision.
  always_comb begin
    pc_aligned = (PC[1:0] == 2'b00);
    latch_pc   = ~Reset & ~Flush & pc_aligned &
                 ((state_q == S_IDLE) | ((state_q == S_HOLD) & DecodeReady));
    PCStall    = ~latch_pc;
  end

  // Next-state and register-update logic; every register holds by default.
  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      S_IDLE: begin
        if (Flush) begin
          instr_valid_d = 1'b0;
          fault_d       = 1'b0;
        end else if (latch_pc) begin
          imem_addr_d = PC;
          imem_req_d  = 1'b1;
          state_d     = S_REQ;
        end else if (!pc_aligned) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end
      end

      S_REQ: begin
        if (IMemAck) begin
          imem_req_d = 1'b0;
          if (Flush) begin
            // Data that arrives with the redirect belongs to the old path.
            state_d = S_IDLE;
          end else begin
            instr_d       = IMemData;
            instr_pc_d    = imem_addr_q;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end else if (Flush) begin
          // Keep the request up so memory sees a clean handshake.
          state_d = S_DRAIN;
        end
      end

      S_HOLD: begin
        if (Flush) begin
          // The buffered instruction is dropped, even if decode was ready.
          instr_valid_d = 1'b0;
          fault_d       = 1'b0;
          state_d       = S_IDLE;
        end else if (DecodeReady) begin
          fetch_count_d = fetch_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          instr_valid_d = 1'b0;
          if (latch_pc) begin
            imem_addr_d = PC;
            imem_req_d  = 1'b1;
            state_d     = S_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end

      S_DRAIN: begin
        if (IMemAck) begin
          imem_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_FAULT: begin
        if (Flush) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with immediate (asynchronous) reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= 32'd0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign IMemReq    = imem_req_q;
  assign IMemAddr   = imem_addr_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign InstrValid = instr_valid_q;
  assign Fault      = fault_q;
  assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios followed by a randomized stream checked against an
// in-order fetch model: the k-th request and k-th delivered instruction must
// both be at base + 4k, with data from a fixed memory function.
module tb_instr_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PC = 32'd0;
  logic        Flush = 1'b0;
  logic        PCStall;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = 32'd0;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        DecodeReady = 1'b0;
  logic        Fault;
  logic [3:0]  FetchCount;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] pc, base, req_addr, s_ipc, s_instr;
  logic        stall_b, acc_b, s_stall, s_valid, s_dr, req_prev;
  int          acc, nreq, dly;

  instr_fetch_unit #(.CNT_WIDTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .PC(PC), .Flush(Flush), .PCStall(PCStall),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
    .IMemData(IMemData), .Instr(Instr), .InstrPC(InstrPC),
    .InstrValid(InstrValid), .DecodeReady(DecodeReady), .Fault(Fault),
    .FetchCount(FetchCount)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] p);
    Reset = 1'b1; Flush = 1'b0; IMemAck = 1'b0; DecodeReady = 1'b0; PC = p;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  task automatic edge1();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // ---------------- reset state and first fetch ----------------
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_req", 32'(IMemReq), 0);
    chk("rst_addr", IMemAddr, 0);
    chk("rst_instr", Instr, 0);
    chk("rst_ipc", InstrPC, 0);
    chk("rst_valid", 32'(InstrValid), 0);
    chk("rst_fault", 32'(Fault), 0);
    chk("rst_count", 32'(FetchCount), 0);
    chk("rst_stall", 32'(PCStall), 1);
    Reset = 1'b0; PC = 32'h0;
    #1 chk("first_latch_stall", 32'(PCStall), 0);
    edge1();
    chk("first_req", 32'(IMemReq), 1);
    chk("first_addr", IMemAddr, 0);
    chk("first_valid_low", 32'(InstrValid), 0);
    IMemAck = 1'b1; IMemData = 32'h8C010004;
    #1 chk("req_stall", 32'(PCStall), 1);
    edge1();
    IMemAck = 1'b0;
    chk("first_valid", 32'(InstrValid), 1);
    chk("first_instr", Instr, 32'h8C010004);
    chk("first_ipc", InstrPC, 0);
    chk("first_req_drop", 32'(IMemReq), 0);

    // ---------------- decode backpressure ----------------
    PC = 32'h4; DecodeReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_stall", 32'(PCStall), 1);
      edge1();
      chk("bp_valid", 32'(InstrValid), 1);
      chk("bp_instr", Instr, 32'h8C010004);
      chk("bp_ipc", InstrPC, 0);
      chk("bp_req", 32'(IMemReq), 0);
      chk("bp_count", 32'(FetchCount), 0);
    end
    DecodeReady = 1'b1;
    #1 chk("bp_release_stall", 32'(PCStall), 0);
    edge1();
    chk("bp_count_inc", 32'(FetchCount), 1);
    chk("bp_next_req", 32'(IMemReq), 1);
    chk("bp_next_addr", IMemAddr, 32'h4);
    chk("bp_valid_drop", 32'(InstrValid), 0);
    DecodeReady = 1'b0; IMemAck = 1'b1; IMemData = 32'h00000013;
    edge1();
    IMemAck = 1'b0;
    chk("bp_count_once", 32'(FetchCount), 1);
    chk("bp_second_ipc", InstrPC, 32'h4);

    // ---------------- back-to-back stream ----------------
    do_reset(32'h40);
    DecodeReady = 1'b1; pc = 32'h40;
    for (int e = 1; e <= 7; e++) begin
      #1 stall_b = PCStall;
      edge1();
      if (!stall_b) pc = pc + 32'd4;
      PC = pc;
      if (e % 2 == 0) begin
        chk("stream_valid", 32'(InstrValid), 1);
        chk("stream_ipc", InstrPC, 32'h40 + 32'(4 * (e / 2 - 1)));
        chk("stream_instr", Instr, memf(32'h40 + 32'(4 * (e / 2 - 1))));
      end else begin
        chk("stream_gap", 32'(InstrValid), 0);
      end
      if (IMemReq) begin IMemAck = 1'b1; IMemData = memf(IMemAddr); end
      else IMemAck = 1'b0;
    end
    chk("stream_count", 32'(FetchCount), 3);

    // ---------------- flush during outstanding request ----------------
    do_reset(32'h80);
    edge1();
    chk("fl_req", 32'(IMemReq), 1);
    chk("fl_addr", IMemAddr, 32'h80);
    Flush = 1'b1; PC = 32'h200;
    #1 chk("fl_stall", 32'(PCStall), 1);
    edge1();
    Flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_req", 32'(IMemReq), 1);
      chk("drain_addr", IMemAddr, 32'h80);
      chk("drain_valid", 32'(InstrValid), 0);
      #1 chk("drain_stall", 32'(PCStall), 1);
      if (i == 1) begin IMemAck = 1'b1; IMemData = 32'hDEADBEEF; end
      edge1();
    end
    IMemAck = 1'b0;
    chk("drain_done_req", 32'(IMemReq), 0);
    chk("drain_no_valid", 32'(InstrValid), 0);
    #1 chk("redir_stall", 32'(PCStall), 0);
    edge1();
    chk("redir_req", 32'(IMemReq), 1);
    chk("redir_addr", IMemAddr, 32'h200);
    chk("redir_valid", 32'(InstrValid), 0);
    IMemAck = 1'b1; IMemData = 32'h11111111;
    edge1();
    IMemAck = 1'b0;
    chk("redir_ipc", InstrPC, 32'h200);
    chk("redir_instr", Instr, 32'h11111111);
    // flush in HOLD while decode is ready: dropped, not counted
    Flush = 1'b1; DecodeReady = 1'b1; PC = 32'h240;
    edge1();
    Flush = 1'b0; DecodeReady = 1'b0;
    chk("holdfl_valid", 32'(InstrValid), 0);
    chk("holdfl_count", 32'(FetchCount), 0);
    chk("holdfl_req", 32'(IMemReq), 0);
    edge1();
    chk("ackfl_req", 32'(IMemReq), 1);
    chk("ackfl_addr", IMemAddr, 32'h240);
    // flush coincident with ack
    Flush = 1'b1; IMemAck = 1'b1; IMemData = 32'hCAFEF00D; PC = 32'h300;
    edge1();
    Flush = 1'b0; IMemAck = 1'b0;
    chk("ackfl_req_drop", 32'(IMemReq), 0);
    chk("ackfl_valid", 32'(InstrValid), 0);
    edge1();
    chk("ackfl_new_req", 32'(IMemReq), 1);
    chk("ackfl_new_addr", IMemAddr, 32'h300);
    IMemAck = 1'b1; IMemData = 32'h22222222;
    edge1();
    IMemAck = 1'b0;
    chk("ackfl_ipc", InstrPC, 32'h300);
    chk("ackfl_instr", Instr, 32'h22222222);

    // ---------------- misaligned PC ----------------
    do_reset(32'h102);
    #1 chk("mis_stall", 32'(PCStall), 1);
    edge1();
    chk("mis_fault", 32'(Fault), 1);
    chk("mis_req", 32'(IMemReq), 0);
    PC = 32'h100;
    for (int i = 0; i < 3; i++) begin
      IMemAck = (i == 1);
      #1 chk("fault_stall", 32'(PCStall), 1);
      edge1();
      chk("fault_req", 32'(IMemReq), 0);
      chk("fault_sticky", 32'(Fault), 1);
    end
    IMemAck = 1'b0; Flush = 1'b1;
    edge1();
    Flush = 1'b0;
    chk("fault_clear", 32'(Fault), 0);
    #1 chk("fault_resume_stall", 32'(PCStall), 0);
    edge1();
    chk("fault_resume_req", 32'(IMemReq), 1);
    chk("fault_resume_addr", IMemAddr, 32'h100);
    IMemAck = 1'b1; IMemData = 32'h33333333;
    edge1();
    IMemAck = 1'b0;
    PC = 32'h106; DecodeReady = 1'b1;
    #1 chk("hold_mis_stall", 32'(PCStall), 1);
    edge1();
    DecodeReady = 1'b0;
    chk("hold_mis_fault", 32'(Fault), 1);
    chk("hold_mis_valid", 32'(InstrValid), 0);
    chk("hold_mis_count", 32'(FetchCount), 1);
    chk("hold_mis_req", 32'(IMemReq), 0);

    // ---------------- counter wrap and async reset mid-HOLD ----------------
    do_reset(32'h400);
    DecodeReady = 1'b1; pc = 32'h400; acc = 0;
    for (int c = 0; c < 100 && acc < 17; c++) begin
      #1 stall_b = PCStall; acc_b = InstrValid && DecodeReady;
      edge1();
      if (acc_b) acc++;
      if (!stall_b) pc = pc + 32'd4;
      PC = pc;
      if (IMemReq) begin IMemAck = 1'b1; IMemData = memf(IMemAddr); end
      else IMemAck = 1'b0;
    end
    chk("wrap_accepts", 32'(acc), 17);
    chk("wrap_count", 32'(FetchCount), 1);
    DecodeReady = 1'b0;
    edge1();
    IMemAck = 1'b0;
    chk("prereset_valid", 32'(InstrValid), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_req", 32'(IMemReq), 0);
    chk("async_addr", IMemAddr, 0);
    chk("async_instr", Instr, 0);
    chk("async_ipc", InstrPC, 0);
    chk("async_valid", 32'(InstrValid), 0);
    chk("async_fault", 32'(Fault), 0);
    chk("async_count", 32'(FetchCount), 0);
    chk("async_stall", 32'(PCStall), 1);

    // ---------------- randomized stream against in-order model ----------------
    base = 32'h1000;
    do_reset(base);
    pc = base; acc = 0; nreq = 0; dly = 0; req_prev = 1'b0; req_addr = 32'd0;
    DecodeReady = 1'($urandom_range(0, 1));
    #1;
    s_stall = PCStall; s_valid = InstrValid; s_dr = DecodeReady;
    s_ipc = InstrPC; s_instr = Instr;
    for (int c = 0; c < 600; c++) begin
      edge1();
      if (s_valid && s_dr) begin
        chk("rnd_ipc", s_ipc, base + 32'(4 * acc));
        chk("rnd_instr", s_instr, memf(base + 32'(4 * acc)));
        acc++;
      end
      if (!s_stall) pc = pc + 32'd4;
      PC = pc;
      chk("rnd_count", 32'(FetchCount), 32'(acc % 16));
      if (IMemReq && !req_prev) begin
        chk("rnd_req_addr", IMemAddr, base + 32'(4 * nreq));
        nreq++;
        req_addr = IMemAddr;
        dly = int'($urandom_range(0, 3));
      end else if (IMemReq) begin
        chk("rnd_addr_stable", IMemAddr, req_addr);
      end
      req_prev = IMemReq;
      if (IMemReq && dly == 0) begin
        IMemAck = 1'b1; IMemData = memf(IMemAddr);
      end else begin
        IMemAck = IMemReq ? 1'b0 : ($urandom_range(0, 3) == 0);
        IMemData = $urandom;
        if (IMemReq) dly--;
      end
      DecodeReady = 1'($urandom_range(0, 1));
      #1;
      s_stall = PCStall; s_valid = InstrValid; s_dr = DecodeReady;
      s_ipc = InstrPC; s_instr = Instr;
    end
    chk("rnd_progress", 32'(acc >= 20), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
